// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD add/subtract sequencer: one shared single-digit BCD adder,
// LSD first, decimal carry rippled through a register, one-cycle done pulse.

module bcd_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_c_o,
    output logic       cout_c_o
);
    logic [4:0] bin_sum;

    // Binary sum, then +6 correction whenever the decimal digit overflows
    always_comb begin
        bin_sum  = 5'(a_i) + 5'(b_i) + 5'(c_i);
        cout_c_o = (bin_sum > 5'd9);
        s_c_o    = cout_c_o ? 4'(bin_sum + 5'd6) : bin_sum[3:0];
    end
endmodule

module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);
    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       opa_q, opa_d;
    logic [W-1:0]       opb_q, opb_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [W-1:0]       b_nines_c;
    logic               in_err_c;
    logic [3:0]         dig_a_c, dig_b_c, dig_s_c;
    logic               dig_cout_c;

    // Nine's complement of b and invalid-digit detection on the incoming operands
    always_comb begin
        b_nines_c = '0;
        in_err_c  = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            b_nines_c[4*i +: 4] = 4'd9 - b[4*i +: 4];
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                in_err_c = 1'b1;
            end
        end
    end

    assign dig_a_c = opa_q[{idx_q, 2'b00} +: 4];
    assign dig_b_c = opb_q[{idx_q, 2'b00} +: 4];

    bcd_adder u_digit_adder (
        .a_i      (dig_a_c),
        .b_i      (dig_b_c),
        .c_i      (carry_q),
        .s_c_o    (dig_s_c),
        .cout_c_o (dig_cout_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new start directly so back-to-back ops skip IDLE
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? b_nines_c : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    err_d   = in_err_c;
                    busy_d  = 1'b1;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                sum_d[{idx_q, 2'b00} +: 4] = dig_s_c;
                carry_d = dig_cout_c;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    cout_d  = dig_cout_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: driver pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.

module tb_bcd_serial_add_ctrl;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum",  32'(sum),  32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
                check("err",  32'(err),  32'(e.e));
            end
        end
    end

    // Issue one op (caller sits at a negedge) and verify busy/done timing
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vsub, input logic vcin,
                         input logic [W-1:0] es, input logic ec, input logic ee);
        int busy_cnt;
        int k;
        exp_t e;
        a = va; b = vb; sub = vsub; cin = vcin; start = 1'b1;
        e.s = es; e.c = ec; e.e = ee;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a = '1; b = '1; sub = ~vsub; cin = ~vcin;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        busy_cnt = 0;
        for (k = 1; k <= int'(DIGITS) + 4; k++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cnt++;
        end
        check("done_latency", 32'(k), 32'(DIGITS + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(DIGITS));
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);

        // Basic add
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
        idle_cycles(1);
        check("hold_sum_idle", 32'(sum), 32'h6912);
        // Overflow and carry-in
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle_cycles(1);
        do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
        idle_cycles(1);
        // Subtract, both signs; cin ignored when subtracting
        do_op(16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0);
        idle_cycles(1);
        do_op(16'h1234, 16'h5000, 1'b1, 1'b1, 16'h6234, 1'b0, 1'b0);
        idle_cycles(1);
        // Invalid digit: raw adder result with err flagged, then a clean op
        do_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h1305, 1'b0, 1'b1);
        idle_cycles(1);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        idle_cycles(1);

        // start held through ADD is ignored: exactly one done
        begin
            exp_t e;
            a = 16'h0450; b = 16'h0550; sub = 1'b0; cin = 1'b0; start = 1'b1;
            e.s = 16'h1000; e.c = 1'b0; e.e = 1'b0;
            exp_q.push_back(e);
            for (int i = 0; i < int'(DIGITS); i++) @(posedge clk);
            #1 start = 1'b0;
            idle_cycles(int'(DIGITS) + 4);
            check("held_start_drained", 32'(exp_q.size()), 32'd0);
        end

        // Back-to-back: second start issued in the DONE cycle
        do_op(16'h0808, 16'h0202, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
        do_op(16'h0100, 16'h0001, 1'b1, 1'b0, 16'h0099, 1'b1, 1'b0);
        idle_cycles(1);

        // Reset mid-operation after the second ADD edge
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle_cycles(1);
        a = 16'h12A4; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("pre_rst_err", 32'(err), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_sum",  32'(sum),  32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_err",  32'(err),  32'd0);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(int'(DIGITS) + 3);
        check("no_done_after_rst", 32'(exp_q.size()), 32'd0);
        do_op(16'h4321, 16'h1111, 1'b0, 1'b1, 16'h5433, 1'b0, 1'b0);
        idle_cycles(2);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end
endmodule
